// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue.
package fetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer storage for fetched {pc, instr} entries with push/pop/count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         push,
    input  entry_t                       wdata,
    input  logic                         pop,
    output entry_t                       rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !clr) mem[wptr_q] <= wdata;
    end

    assign rdata = mem[rptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: issues imem reads for accepted PCs and queues {pc, instr} for decode.
// Optional same-cycle bypass to decode when the queue is empty: define FETCH_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_valid,
    input  logic [WIDTH-1:0]   pc,
    output logic               pc_ready,
    output logic               imem_en,
    output logic [WIDTH-1:0]   imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               flush,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [WIDTH-1:0]   id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic               id_misaligned
);

    localparam int unsigned CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [WIDTH-1:0]   pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic             inflight_q;
    logic [WIDTH-1:0] pc_q;
    logic             accept;
    logic             push_valid;
    logic             fifo_push;
    logic             fifo_pop;
    logic             head_valid;
    logic [CW-1:0]    count;
    logic [CW:0]      credit_used;
    entry_t           wdata;
    entry_t           fifo_rdata;
    entry_t           head;

    // The in-flight read holds a slot, so a full queue can never be overrun.
    assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_q};
    assign pc_ready    = !flush && (credit_used < (CW+1)'(DEPTH));
    assign accept      = pc_valid && pc_ready;
    assign imem_en     = accept;
    assign imem_addr   = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 1'b0;
            pc_q       <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) pc_q <= pc;
        end
    end

    assign push_valid = inflight_q && !flush;

    always_comb begin
        wdata       = '0;
        wdata.pc    = pc_q;
        wdata.instr = imem_rdata;
    end

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass     = push_valid && (count == '0);
    // A bypassed entry taken by decode this cycle is never written.
    assign fifo_push  = push_valid && !(bypass && id_ready);
    assign head_valid = (count != '0) || bypass;
    assign head       = bypass ? wdata : fifo_rdata;
`else
    assign fifo_push  = push_valid;
    assign head_valid = (count != '0);
    assign head       = fifo_rdata;
`endif

    assign fifo_pop = (count != '0) && id_ready && !flush;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (fifo_push),
        .wdata (wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (count)
    );

    always_comb begin
        id_valid      = head_valid;
        id_pc         = '0;
        id_instr      = NOP_INSTR;
        id_misaligned = 1'b0;
        if (head_valid) begin
            id_pc         = head.pc;
            id_instr      = head.instr;
            id_misaligned = (head.pc[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default DEPTH=4, WIDTH=32).
module tb_fetch_queue;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        pc_valid;
    logic [31:0] pc;
    logic        pc_ready;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_misaligned;

    int checks = 0;
    int errors = 0;

    fetch_queue #(
        .WIDTH (32),
        .DEPTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_valid      (pc_valid),
        .pc            (pc),
        .pc_ready      (pc_ready),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .flush         (flush),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_misaligned (id_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word = 0xA + addr/4, except 0x200 which returns 0xDEAD.
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a == 32'h200) ? 32'h0000_DEAD : 32'hA + (a >> 2);
    endfunction

    always @(posedge clk) imem_rdata <= imem_en ? word(imem_addr) : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pc_valid = 1'b0; pc = '0; flush = 1'b0; id_ready = 1'b0;
        #3;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", id_valid); end
        checks++; if (id_instr !== 32'h13) begin errors++; $display("FAIL rst_instr: got %h want 00000013", id_instr); end
        checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", id_pc); end
        checks++; if (id_misaligned !== 1'b0) begin errors++; $display("FAIL rst_mis: got %b want 0", id_misaligned); end
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", pc_ready); end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL rst_imem_en: got %b want 0", imem_en); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        step();
    endtask

    task automatic test_stream();
        id_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            int k;
            pc_valid = (c < 3);
            pc       = 32'(4 * c);
            #1;
            k = c - LAT;
            if (k >= 0 && k < 3) begin
                checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %b want 1", c, id_valid); end
                checks++; if (id_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc c%0d: got %h want %h", c, id_pc, 4 * k); end
                checks++; if (id_instr !== 32'hA + 32'(k)) begin errors++; $display("FAIL stream_instr c%0d: got %h want %h", c, id_instr, 32'hA + 32'(k)); end
            end else begin
                checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL stream_idle c%0d: got %b want 0", c, id_valid); end
            end
            step();
        end
        id_ready = 1'b0;
    endtask

    task automatic test_full_and_pop();
        int          acc;
        logic [31:0] nxt;
        acc = 0; nxt = 32'h0; id_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            pc_valid = 1'b1; pc = nxt;
            #1;
            if (c == 4) begin
                checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL full_ready_drop: got %b want 0", pc_ready); end
            end
            if (pc_ready) begin acc++; nxt += 4; end
            step();
        end
        checks++; if (acc != 4) begin errors++; $display("FAIL full_accepted: got %0d want 4", acc); end
        checks++; if (id_pc !== 32'h0 || id_instr !== 32'hA) begin errors++; $display("FAIL full_head: got %h/%h want 0/a", id_pc, id_instr); end
        id_ready = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %b want 0", pc_ready); end
        step();
        id_ready = 1'b0;
        #1;
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready: got %b want 1", pc_ready); end
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h10) begin errors++; $display("FAIL after_pop_fetch: got %b/%h want 1/10", imem_en, imem_addr); end
        step();
        pc_valid = 1'b0; id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 + 4 * k) || id_instr !== 32'hB + 32'(k))
                begin errors++; $display("FAIL drain%0d: got %b/%h/%h want 1/%h/%h", k, id_valid, id_pc, id_instr, 4 + 4 * k, 32'hB + 32'(k)); end
            step();
        end
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b want 0", id_valid); end
        id_ready = 1'b0;
        step();
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        pc_valid = 1'b1; pc = 32'h0;   step();
        pc = 32'h4;                    step();
        pc = 32'h200;                  step();
        pc_valid = 1'b0; flush = 1'b1; id_ready = 1'b1;
        #1;
        checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", pc_ready); end
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL flush_cycle_valid: got %b want 1", id_valid); end
        step();
        flush = 1'b0; id_ready = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h13) begin errors++; $display("FAIL post_flush: got %b/%h want 0/00000013", id_valid, id_instr); end
        checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready: got %b want 1", pc_ready); end
        pc_valid = 1'b1; pc = 32'h100;
        step();
        pc_valid = 1'b0;
        step();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instr !== 32'h4A)
            begin errors++; $display("FAIL flush_refetch: got %b/%h/%h want 1/100/4a", id_valid, id_pc, id_instr); end
        id_ready = 1'b1;
        step();
        #1;
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_no_dead: got %b/%h want empty", id_valid, id_instr); end
        id_ready = 1'b0;
        step();
    endtask

    task automatic test_misaligned();
        id_ready = 1'b0;
        pc_valid = 1'b1; pc = 32'h6;
        step();
        pc_valid = 1'b0;
        step();
        #1;
        checks++; if (id_valid !== 1'b1 || id_misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_flag: got %b/%b want 1/1", id_valid, id_misaligned); end
        checks++; if (id_pc !== 32'h6 || id_instr !== 32'hB) begin errors++; $display("FAIL misaligned_entry: got %h/%h want 6/b", id_pc, id_instr); end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        id_ready = 1'b0;
        pc_valid = 1'b1; pc = 32'h0; step();
        pc = 32'h4;                  step();
        pc = 32'h8;                  step();
        pc_valid = 1'b0;             step();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0) begin errors++; $display("FAIL async_pre: got %b/%h want 1/0", id_valid, id_pc); end
        rst = 1'b0;
        #1;
        checks++; if (id_valid !== 1'b0 || id_instr !== 32'h13) begin errors++; $display("FAIL async_rst: got %b/%h want 0/00000013", id_valid, id_instr); end
        checks++; if (id_pc !== 32'h0 || id_misaligned !== 1'b0) begin errors++; $display("FAIL async_rst_pc: got %h/%b want 0/0", id_pc, id_misaligned); end
        @(posedge clk); #1;
        rst = 1'b1;
        pc_valid = 1'b1; pc = 32'h20;
        step();
        pc_valid = 1'b0;
        #1;
        checks++; if (id_valid !== (LAT == 1)) begin errors++; $display("FAIL async_relaunch_lat: got %b want %b", id_valid, LAT == 1); end
        step();
        #1;
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h20 || id_instr !== 32'h12)
            begin errors++; $display("FAIL async_relaunch: got %b/%h/%h want 1/20/12", id_valid, id_pc, id_instr); end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; pc_valid = 1'b0; pc = '0; flush = 1'b0; id_ready = 1'b0;
        test_reset();
        test_stream();
        test_reset();
        test_full_and_pop();
        test_reset();
        test_flush();
        test_reset();
        test_misaligned();
        test_reset();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Fetch stage directly downstream of the PC unit: consumes each PC, issues a synchronous instruction-memory read, and captures the returned word.
- Buffers {pc, instr} pairs in a DEPTH-entry FIFO and hands them to decode over a valid/ready handshake.
- Back-pressures the PC unit through pc_ready, and discards everything held or in flight on a branch/jump flush.

Parameters:
- WIDTH, 32, address/PC width.
- DEPTH, 4, queue entries; power of two, ≥2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- pc_valid  in  1  PC unit presents a fetch address.
- pc  in  WIDTH  fetch address.
- pc_ready  out  1  queue can accept a fetch this cycle; the PC unit holds pc while it is 0.
- imem_en  out  1  instruction-memory read strobe.
- imem_addr  out  WIDTH  read address.
- imem_rdata  in  32  read data, valid exactly one cycle after imem_en.
- flush  in  1  redirect; drops queue contents and any in-flight read.
- id_valid  out  1  decode entry available.
- id_ready  in  1  decode consumes the entry.
- id_pc  out  WIDTH  PC of the head entry.
- id_instr  out  32  instruction of the head entry.
- id_misaligned  out  1  head entry's pc[1:0] != 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - count, read pointer, write pointer and inflight_q go to 0.
  - id_valid=0, id_pc=0, id_instr=NOP (32'h00000013), id_misaligned=0.
  - An imem response pending at reset is discarded.
- Accept:
  - accept = pc_valid & pc_ready.
  - imem_en = accept; imem_addr = pc (combinational passthrough).
  - On accept, register inflight_q=1 and pc_q=pc; otherwise inflight_q=0.
- Credit:
  - pc_ready = !flush & ((count + inflight_q) < DEPTH).
  - A same-cycle pop earns no credit; this rules out overflow by construction.
- Push: in the cycle with inflight_q=1 and flush=0, write {pc_q, imem_rdata} at the write pointer.
- Pop: id_valid & id_ready advances the read pointer.
- Pointers and count:
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - count is $clog2(DEPTH+1) bits: +1 on push only, -1 on pop only, unchanged on both.
- Outputs: id_valid = (count != 0). When id_valid=0: id_instr=NOP, id_pc=0, id_misaligned=0.
- Latency without bypass: PC accepted in cycle N, imem data arrives in N+1, entry is pushed at the N+1 edge, id_valid=1 in N+2.
- Sustained throughput: one instruction per cycle while id_ready=1.
- Flush (synchronous, priority over push/pop/accept):
  - Next edge: count=0, pointers=0, inflight_q=0.
  - The response arriving in the flush cycle is dropped.
  - pc_ready=0 during the flush cycle.
  - id_valid may still be 1 in the flush cycle, but a pop in that cycle is ignored.
- Boundaries:
  - Full with a pop: pc_ready stays 0 that cycle and rises the next.
  - Empty queue with a push: entry becomes visible the next cycle (unless bypass is enabled).

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined, applies when count==0 and a push occurs:
  - Outputs: id_valid=1, id_pc=pc_q, id_instr=imem_rdata in the same cycle.
  - id_ready=1: the entry is consumed and not written, so count stays 0.
  - id_ready=0: the entry is written normally.
  - Latency becomes N+1.
- Undefined: no bypass path; latency is N+2.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W=32 and NOP_INSTR=32'h00000013.
  - typedef fetch_entry_t, a packed struct {logic [WIDTH-1:0] pc; logic [INSTR_W-1:0] instr}.
- Sub-module fetch_fifo: synchronous storage with push/pop/count, parameterised on DEPTH and entry type.
- fetch_queue contains the credit, in-flight, flush and bypass logic.

Test Plan:
- Reset then pc_valid=1 with pc=0x0,0x4,0x8, id_ready=1, imem returning 0xA,0xB,0xC → id outputs {0x0,0xA},{0x4,0xB},{0x8,0xC} from cycle 2 (cycle 1 with bypass), one per cycle.
- id_ready=0, stream pcs 0x0..0x1C → exactly 4 accepted; pc_ready=0 once count+inflight_q=4; count holds at 4 and no entry is overwritten.
- Full queue, then id_ready=1 for one cycle → one pop, pc_ready=1 the following cycle, next pc=0x10 fetched in order.
- Two entries queued plus one in flight, flush=1 → next cycle id_valid=0 and count=0; response 0xDEAD arriving in the flush cycle never appears; new pc=0x100 delivered normally.
- pc=0x6 accepted → id_misaligned=1 with id_pc=0x6.
- rst=0 asynchronously mid-stream with 3 entries held → id_valid=0 and id_instr=0x00000013 before the next edge; after release, first fetch behaves as after a clean reset.
